// File: rtl/board_state_if.sv
// Button/winner inputs and board/cursor/status outputs of the board_state stage.
// Pure signal bundle: no storage, no latency of its own.
// No backpressure: buttons are levels, outputs are registered state.
interface board_state_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_place;
    logic [1:0] winner;
    logic [7:0] btemp1;
    logic [7:0] btemp2;
    logic [7:0] btemp3;
    logic [7:0] redtemp1;
    logic [7:0] redtemp2;
    logic [7:0] redtemp3;
    logic [1:0] cursor_row;
    logic [1:0] cursor_col;
    logic       turn;
    logic [3:0] move_count;
    logic       game_over;
    logic       draw;
    logic       illegal;

    // Environment side: drives buttons and the controller's winner result.
    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_place, winner,
        input  btemp1, btemp2, btemp3, redtemp1, redtemp2, redtemp3,
        input  cursor_row, cursor_col, turn, move_count, game_over, draw, illegal
    );

    // board_state side.
    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_place, winner,
        output btemp1, btemp2, btemp3, redtemp1, redtemp2, redtemp3,
        output cursor_row, cursor_col, turn, move_count, game_over, draw, illegal
    );
endinterface

// File: rtl/board_state.sv
// Tic-tac-toe board holder: button edges -> cursor moves / placements, turn and move tracking.
// Latency: one cycle from button edge to outputs; turn/end decision SETTLE_CYCLES after placement.
// No backpressure: edges during SETTLE or OVER are dropped, history still tracks the levels.
module board_state #(
    parameter bit BLUE_FIRST    = 1'b1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    board_state_if.slave io_bus
);

    localparam int CW = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        SETTLE = 2'd1,
        OVER   = 2'd2
    } state_t;

    state_t          r_state;
    logic [8:0]      r_blue;      // cell index = row*3 + col
    logic [8:0]      r_red;
    logic [1:0]      r_row;
    logic [1:0]      r_col;
    logic            r_turn;
    logic [3:0]      r_cnt;
    logic [CW-1:0]   r_settle;
    logic            r_draw;
    logic            r_illegal;
    logic [4:0]      r_hist;      // {place, up, down, left, right}

    state_t          w_state_nxt;
    logic [8:0]      w_blue_nxt;
    logic [8:0]      w_red_nxt;
    logic [1:0]      w_row_nxt;
    logic [1:0]      w_col_nxt;
    logic            w_turn_nxt;
    logic [3:0]      w_cnt_nxt;
    logic [CW-1:0]   w_settle_nxt;
    logic            w_draw_nxt;
    logic            w_illegal_nxt;

    logic [4:0]      w_btn;
    logic [4:0]      w_edge;
    logic [3:0]      w_idx;
    logic [8:0]      w_cell;
    logic            w_occupied;

    assign w_btn      = {io_bus.btn_place, io_bus.btn_up, io_bus.btn_down,
                         io_bus.btn_left, io_bus.btn_right};
    assign w_edge     = w_btn & ~r_hist;
    assign w_idx      = ({2'b00, r_row} * 4'd3) + {2'b00, r_col};
    assign w_cell     = 9'd1 << w_idx;
    assign w_occupied = |((r_blue | r_red) & w_cell);

    // Next-state and next-board decision; place wins over moves, one action per cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_blue_nxt    = r_blue;
        w_red_nxt     = r_red;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_turn_nxt    = r_turn;
        w_cnt_nxt     = r_cnt;
        w_settle_nxt  = r_settle;
        w_draw_nxt    = r_draw;
        w_illegal_nxt = 1'b0;
        case (r_state)
            PLAY: begin
                if (w_edge[4]) begin
                    // A decided game (winner already set) swallows the press silently.
                    if (io_bus.winner == 2'b00) begin
                        if (w_occupied) begin
                            w_illegal_nxt = 1'b1;
                        end else begin
                            if (r_turn) begin
                                w_red_nxt = r_red | w_cell;
                            end else begin
                                w_blue_nxt = r_blue | w_cell;
                            end
                            w_cnt_nxt    = (r_cnt == 4'd9) ? 4'd9 : r_cnt + 4'd1;
                            w_settle_nxt = CW'(SETTLE_CYCLES - 1);
                            w_state_nxt  = SETTLE;
                        end
                    end
                end else if (w_edge[3]) begin
                    w_row_nxt = (r_row == 2'd0) ? 2'd2 : r_row - 2'd1;
                end else if (w_edge[2]) begin
                    w_row_nxt = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
                end else if (w_edge[1]) begin
                    w_col_nxt = (r_col == 2'd0) ? 2'd2 : r_col - 2'd1;
                end else if (w_edge[0]) begin
                    w_col_nxt = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
                end
            end
            SETTLE: begin
                // Wait for the registered winner to reflect the new board before deciding.
                if (r_settle == '0) begin
                    if ((io_bus.winner != 2'b00) || (r_cnt == 4'd9)) begin
                        w_state_nxt = OVER;
                        w_draw_nxt  = (io_bus.winner == 2'b00);
                    end else begin
                        w_turn_nxt  = ~r_turn;
                        w_state_nxt = PLAY;
                    end
                end else begin
                    w_settle_nxt = r_settle - CW'(1);
                end
            end
            OVER: begin
            end
            default: begin
                w_state_nxt = PLAY;
            end
        endcase
    end

    // State register; button history is preset so levels held through reset stay inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= PLAY;
            r_blue    <= '0;
            r_red     <= '0;
            r_row     <= 2'd1;
            r_col     <= 2'd1;
            r_turn    <= !BLUE_FIRST;
            r_cnt     <= 4'd0;
            r_settle  <= '0;
            r_draw    <= 1'b0;
            r_illegal <= 1'b0;
            r_hist    <= 5'b11111;
        end else begin
            r_state   <= w_state_nxt;
            r_blue    <= w_blue_nxt;
            r_red     <= w_red_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_turn    <= w_turn_nxt;
            r_cnt     <= w_cnt_nxt;
            r_settle  <= w_settle_nxt;
            r_draw    <= w_draw_nxt;
            r_illegal <= w_illegal_nxt;
            r_hist    <= w_btn;
        end
    end

    assign io_bus.btemp1     = {3'b000, r_blue[2], 1'b0, r_blue[1], 1'b0, r_blue[0]};
    assign io_bus.btemp2     = {3'b000, r_blue[5], 1'b0, r_blue[4], 1'b0, r_blue[3]};
    assign io_bus.btemp3     = {3'b000, r_blue[8], 1'b0, r_blue[7], 1'b0, r_blue[6]};
    assign io_bus.redtemp1   = {3'b000, r_red[2],  1'b0, r_red[1],  1'b0, r_red[0]};
    assign io_bus.redtemp2   = {3'b000, r_red[5],  1'b0, r_red[4],  1'b0, r_red[3]};
    assign io_bus.redtemp3   = {3'b000, r_red[8],  1'b0, r_red[7],  1'b0, r_red[6]};
    assign io_bus.cursor_row = r_row;
    assign io_bus.cursor_col = r_col;
    assign io_bus.turn       = r_turn;
    assign io_bus.move_count = r_cnt;
    assign io_bus.game_over  = (r_state == OVER);
    assign io_bus.draw       = r_draw;
    assign io_bus.illegal    = r_illegal;

endmodule

// File: tb/tb_board_state.sv
// Bench for board_state: game-level reference model plus a registered winner controller model.
// Latency: each button press is given its full settle window before outputs are compared.
// No backpressure: buttons are driven as levels from tasks.
module tb_board_state;

    localparam int SC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_state_if bus ();

    board_state #(
        .BLUE_FIRST   (1'b1),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Controller model: registered winner computed from the rows, or a manual value.
    logic       ctl_manual;
    logic [1:0] ctl_val;

    int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                         '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    function automatic logic [8:0] cells_of(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
        return {c[4], c[2], c[0], b[4], b[2], b[0], a[4], a[2], a[0]};
    endfunction

    function automatic logic has_line(input logic [8:0] m);
        logic hit = 1'b0;
        for (int k = 0; k < 8; k++)
            if (m[lines[k][0]] && m[lines[k][1]] && m[lines[k][2]]) hit = 1'b1;
        return hit;
    endfunction

    always @(posedge clk) begin
        if (ctl_manual)
            bus.winner <= ctl_val;
        else if (has_line(cells_of(bus.btemp1, bus.btemp2, bus.btemp3)))
            bus.winner <= 2'b10;
        else if (has_line(cells_of(bus.redtemp1, bus.redtemp2, bus.redtemp3)))
            bus.winner <= 2'b01;
        else
            bus.winner <= 2'b00;
    end

    // Game-level reference model.
    int m_board [9];   // 0 empty, 1 blue, 2 red
    int m_r, m_c, m_turn, m_cnt;
    bit m_over, m_draw;

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_r = 1; m_c = 1; m_turn = 0; m_cnt = 0; m_over = 0; m_draw = 0;
    endfunction

    function automatic int model_winner();
        int w = 0;
        for (int k = 0; k < 8; k++)
            if (m_board[lines[k][0]] != 0 && m_board[lines[k][0]] == m_board[lines[k][1]] &&
                m_board[lines[k][1]] == m_board[lines[k][2]])
                w = m_board[lines[k][0]];
        return w;
    endfunction

    // Applies one press (mask {place,up,down,left,right}); returns the expected illegal pulse.
    function automatic bit model_press(input logic [4:0] m);
        int idx, w;
        if (m_over || m == 5'b0) return 1'b0;
        if (m[4]) begin
            if (ctl_manual && ctl_val != 2'b00) return 1'b0;
            idx = m_r * 3 + m_c;
            if (m_board[idx] != 0) return 1'b1;
            m_board[idx] = m_turn + 1;
            m_cnt++;
            w = ctl_manual ? 0 : model_winner();
            if (w != 0 || m_cnt == 9) begin
                m_over = 1;
                m_draw = (w == 0);
            end else begin
                m_turn = 1 - m_turn;
            end
        end else if (m[3]) m_r = (m_r + 2) % 3;
        else if (m[2])     m_r = (m_r + 1) % 3;
        else if (m[1])     m_c = (m_c + 2) % 3;
        else               m_c = (m_c + 1) % 3;
        return 1'b0;
    endfunction

    function automatic logic [58:0] exp_vec();
        logic [7:0] bw [3];
        logic [7:0] rw [3];
        for (int r = 0; r < 3; r++) begin
            bw[r] = 8'h00;
            rw[r] = 8'h00;
            for (int c = 0; c < 3; c++) begin
                if (m_board[r*3+c] == 1) bw[r][2*c] = 1'b1;
                if (m_board[r*3+c] == 2) rw[r][2*c] = 1'b1;
            end
        end
        return {bw[0], bw[1], bw[2], rw[0], rw[1], rw[2], 2'(m_r), 2'(m_c),
                1'(m_turn), 4'(m_cnt), m_over, m_draw};
    endfunction

    function automatic logic [58:0] obs_vec();
        return {bus.btemp1, bus.btemp2, bus.btemp3, bus.redtemp1, bus.redtemp2, bus.redtemp3,
                bus.cursor_row, bus.cursor_col, bus.turn, bus.move_count, bus.game_over, bus.draw};
    endfunction

    task automatic set_btns(input logic [4:0] m);
        bus.btn_place = m[4];
        bus.btn_up    = m[3];
        bus.btn_down  = m[2];
        bus.btn_left  = m[1];
        bus.btn_right = m[0];
    endtask

    task automatic do_reset(input logic [4:0] held);
        @(negedge clk);
        rst = 1'b1;
        set_btns(held);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One press: high for one edge, then low; il1/il2 sample illegal on the two following cycles.
    task automatic press(input logic [4:0] m, output logic il1, output logic il2);
        @(negedge clk);
        set_btns(m);
        @(negedge clk);
        il1 = bus.illegal;
        set_btns(5'b0);
        @(negedge clk);
        il2 = bus.illegal;
        repeat (SC + 1) @(negedge clk);
    endtask

    task automatic act(input logic [4:0] m);
        logic a, b;
        bit   e;
        e = model_press(m);
        press(m, a, b);
    endtask

    task automatic goto_cell(input int r, input int c);
        while (m_r != r) act((m_r < r) ? 5'b00100 : 5'b01000);
        while (m_c != c) act((m_c < c) ? 5'b00001 : 5'b00010);
    endtask

    task automatic place_at(input int r, input int c);
        goto_cell(r, c);
        act(5'b10000);
    endtask

    task automatic test_reset();
        ctl_manual = 1'b0;
        do_reset(5'b10000);
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        n_total++;
        if (bus.illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", bus.illegal);
        else n_pass++;
        repeat (2) @(negedge clk);
        set_btns(5'b0);
        repeat (3) @(negedge clk);
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL held_release: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        // First genuine press: check rows immediately and turn toggle exactly SC edges later.
        set_btns(5'b10000);
        @(negedge clk);
        n_total++;
        if ({bus.btemp2, bus.move_count, bus.turn} !== {8'b00000100, 4'd1, 1'b0})
            $display("FAIL first_place: got %b/%0d/%b want 00000100/1/0", bus.btemp2, bus.move_count, bus.turn);
        else n_pass++;
        set_btns(5'b0);
        for (int j = 1; j <= SC; j++) begin
            @(negedge clk);
            n_total++;
            if (bus.turn !== (j == SC)) $display("FAIL turn_timing_%0d: got %b want %b", j, bus.turn, (j == SC));
            else n_pass++;
        end
        void'(model_press(5'b10000));
        repeat (2) @(negedge clk);
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL after_first: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_cursor_wrap();
        do_reset(5'b0);
        act(5'b00010);
        act(5'b00010);
        act(5'b01000);
        n_total++;
        if ({bus.cursor_row, bus.cursor_col} !== 4'b0010)
            $display("FAIL cursor_wrap: got (%0d,%0d) want (0,2)", bus.cursor_row, bus.cursor_col);
        else n_pass++;
        act(5'b10000);
        n_total++;
        if (bus.btemp1 !== 8'b00010000) $display("FAIL wrap_place: got %b want 00010000", bus.btemp1);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL wrap_state: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic a, b;
        bit   e;
        do_reset(5'b0);
        place_at(1, 1);
        e = model_press(5'b10000);
        press(5'b10000, a, b);
        n_total++;
        if ({a, b} !== {e, 1'b0}) $display("FAIL illegal_pulse: got %b%b want %b0", a, b, e);
        else n_pass++;
        n_total++;
        if ({bus.redtemp2, bus.turn, bus.move_count} !== {8'h00, 1'b1, 4'd1})
            $display("FAIL illegal_state: got %b/%b/%0d want 0/1/1", bus.redtemp2, bus.turn, bus.move_count);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL illegal_model: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_blue_win();
        logic       a, b;
        logic [4:0] m;
        bit         e;
        do_reset(5'b0);
        place_at(0, 0); place_at(1, 0); place_at(0, 1); place_at(1, 1); place_at(0, 2);
        n_total++;
        if ({bus.game_over, bus.draw, bus.move_count, bus.btemp1} !== {1'b1, 1'b0, 4'd5, 8'b00010101})
            $display("FAIL blue_win: got %b/%b/%0d/%b want 1/0/5/00010101",
                     bus.game_over, bus.draw, bus.move_count, bus.btemp1);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            m = 5'($urandom_range(1, 31));
            e = model_press(m);
            press(m, a, b);
            n_total++;
            if ({a, b, obs_vec()} !== {e, 1'b0, exp_vec()})
                $display("FAIL over_frozen_%0d: got %b%b %h want %b0 %h", k, a, b, obs_vec(), e, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_draw();
        logic [7:0] any;
        do_reset(5'b0);
        ctl_manual = 1'b1;
        ctl_val    = 2'b00;
        for (int i = 0; i < 9; i++) place_at(i / 3, i % 3);
        n_total++;
        if ({bus.game_over, bus.draw, bus.move_count} !== {1'b1, 1'b1, 4'd9})
            $display("FAIL draw_end: got %b/%b/%0d want 1/1/9", bus.game_over, bus.draw, bus.move_count);
        else n_pass++;
        any = bus.btemp1 | bus.btemp2 | bus.btemp3 | bus.redtemp1 | bus.redtemp2 | bus.redtemp3;
        n_total++;
        if ((any & 8'hEA) !== 8'h00) $display("FAIL draw_reserved: got %b want 000x0x0x zeros", any);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL draw_model: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        ctl_manual = 1'b0;
    endtask

    task automatic test_reset_settle();
        logic seen_ill;
        do_reset(5'b0);
        @(negedge clk);
        set_btns(5'b10000);
        @(negedge clk);
        set_btns(5'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen_ill = bus.illegal;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL settle_reset: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        for (int j = 0; j < SC + 2; j++) begin
            @(negedge clk);
            seen_ill = seen_ill | bus.illegal;
        end
        n_total++;
        if ({seen_ill, obs_vec()} !== {1'b0, exp_vec()})
            $display("FAIL settle_no_toggle: got %b %h want 0 %h", seen_ill, obs_vec(), exp_vec());
        else n_pass++;
        act(5'b11000);
        n_total++;
        if ({bus.cursor_row, bus.cursor_col, bus.btemp2} !== {2'd1, 2'd1, 8'b00000100})
            $display("FAIL place_over_up: got (%0d,%0d) %b want (1,1) 00000100",
                     bus.cursor_row, bus.cursor_col, bus.btemp2);
        else n_pass++;
    endtask

    task automatic test_winner_block();
        logic a, b;
        bit   e;
        do_reset(5'b0);
        ctl_manual = 1'b1;
        ctl_val    = 2'b10;
        repeat (2) @(negedge clk);
        e = model_press(5'b10000);
        press(5'b10000, a, b);
        n_total++;
        if ({a, b, obs_vec()} !== {e, 1'b0, exp_vec()})
            $display("FAIL winner_block: got %b%b %h want %b0 %h", a, b, obs_vec(), e, exp_vec());
        else n_pass++;
        ctl_manual = 1'b0;
        ctl_val    = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic       a, b;
        logic [4:0] m;
        bit         e;
        for (int g = 0; g < 6; g++) begin
            do_reset(5'b0);
            for (int k = 0; k < 60 && !m_over; k++) begin
                case ($urandom_range(0, 7))
                    0, 1:    m = 5'b10000;
                    2:       m = 5'b01000;
                    3:       m = 5'b00100;
                    4:       m = 5'b00010;
                    5:       m = 5'b00001;
                    default: m = 5'($urandom_range(1, 31));
                endcase
                e = model_press(m);
                press(m, a, b);
                n_total++;
                if ({a, b, obs_vec()} !== {e, 1'b0, exp_vec()})
                    $display("FAIL random_g%0d_k%0d: got %b%b %h want %b0 %h", g, k, a, b, obs_vec(), e, exp_vec());
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        ctl_manual = 1'b1;
        ctl_val    = 2'b00;
        set_btns(5'b0);
        model_reset();
        test_reset();
        test_cursor_wrap();
        test_illegal();
        test_blue_win();
        test_draw();
        test_reset_settle();
        test_winner_block();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
